// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and payload types for the memory bus arbiter.
//   TAG_INST / TAG_DATA : in-flight tag values recorded per accepted transaction
//   SIZE_WORD           : access size driven for instruction fetches
//   mem_req_t           : request payload carried alongside req
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;

    localparam logic              TAG_INST  = 1'b0;
    localparam logic              TAG_DATA  = 1'b1;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// SRAM-like request/response channel (req + payload, addr_ok, data_ok, rdata).
//   master : side that issues requests (drives req/pl, receives handshakes/rdata)
//   slave  : side that accepts requests (receives req/pl, drives handshakes/rdata)
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    logic              req;
    mem_req_t          pl;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output pl, input addr_ok, input data_ok, input rdata);
    modport slave  (input req, input pl, output addr_ok, output data_ok, output rdata);

endinterface

// File: rtl/mem_bus_arbiter_tag_fifo.sv
// Ordered FIFO of 1-bit requester tags for in-flight bus transactions.
//   clk, reset : clock, synchronous active-high reset
//   push, push_tag : enqueue a tag
//   pop        : dequeue the head tag (caller guarantees non-empty)
//   head       : tag at the head of the FIFO
//   count      : number of stored tags (0..DEPTH)
module mem_bus_arbiter_tag_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   push_tag,
    input  logic                   pop,
    output logic                   head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    assign head = mem[rptr];

    // Power-of-two depth lets the pointers wrap without explicit compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_tag;
                wptr      <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch (inst) and memory-stage (data)
// ports, with grant lock, starvation guard and in-order response routing.
//   clk, reset : clock, synchronous active-high reset
//   inst_if    : fetch port (read-only word requests)
//   data_if    : data port
//   bus_if     : downstream bus toward the cache/AXI bridge
//   proto_err  : sticky; bus returned data_ok with nothing in flight
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 3
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_arbiter_if.slave   inst_if,
    mem_bus_arbiter_if.slave   data_if,
    mem_bus_arbiter_if.master  bus_if,
    output logic               proto_err
);

    localparam int unsigned PTR_W    = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic                grant_tag;
    logic                granted_req;
    logic                full;
    logic                fifo_empty;
    logic                starving;
    logic                accept;
    logic                ret_valid;
    logic                fifo_head;
    logic [CNT_W-1:0]    fifo_count;
    logic                locked;
    logic                lock_owner;
    logic [STARVE_W-1:0] starve_cnt;
    mem_req_t            inst_pl;

    assign full       = (fifo_count == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (fifo_count == '0);
    assign starving   = (starve_cnt == STARVE_W'(STARVE_LIMIT)) && inst_if.req;

    // Grant: lock owner first, else data unless inst is starving.
    always_comb begin
        grant_tag = TAG_INST;
        if (locked) begin
            grant_tag = lock_owner;
        end else if (data_if.req && !starving) begin
            grant_tag = TAG_DATA;
        end else if (inst_if.req) begin
            grant_tag = TAG_INST;
        end else if (data_if.req) begin
            grant_tag = TAG_DATA;
        end
    end

    assign granted_req = (grant_tag == TAG_DATA) ? data_if.req : inst_if.req;

    // Fetches are always word reads.
    always_comb begin
        inst_pl       = '0;
        inst_pl.wr    = 1'b0;
        inst_pl.size  = SIZE_WORD;
        inst_pl.addr  = inst_if.pl.addr;
        inst_pl.wdata = '0;
    end

    // Full check uses registered count, so a same-cycle pop does not unblock issue.
    assign bus_if.req = granted_req && !full && !reset;
    assign bus_if.pl  = (grant_tag == TAG_DATA) ? data_if.pl : inst_pl;
    assign accept     = bus_if.req && bus_if.addr_ok;

    assign inst_if.addr_ok = accept && (grant_tag == TAG_INST);
    assign data_if.addr_ok = accept && (grant_tag == TAG_DATA);

    // Responses are routed by the oldest in-flight tag.
    assign ret_valid       = bus_if.data_ok && !fifo_empty && !reset;
    assign inst_if.data_ok = ret_valid && (fifo_head == TAG_INST);
    assign data_if.data_ok = ret_valid && (fifo_head == TAG_DATA);
    assign inst_if.rdata   = bus_if.rdata;
    assign data_if.rdata   = bus_if.rdata;

    mem_bus_arbiter_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept),
        .push_tag (grant_tag),
        .pop      (ret_valid),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    // Lock, starvation counter and protocol error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked     <= 1'b0;
            lock_owner <= TAG_INST;
            starve_cnt <= '0;
            proto_err  <= 1'b0;
        end else begin
            if (accept) begin
                locked <= 1'b0;
            end else if (bus_if.req) begin
                locked     <= 1'b1;
                lock_owner <= grant_tag;
            end

            if (accept) begin
                if (grant_tag == TAG_INST) begin
                    starve_cnt <= '0;
                end else if (inst_if.req && (starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
                    starve_cnt <= starve_cnt + STARVE_W'(1);
                end
            end

            if (bus_if.data_ok && fifo_empty) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

- Shares one SRAM-like memory bus between the instruction-fetch port (driven by the fetch stage) and the data port (driven by the memory stage).
- Arbitrates requests with a lock and a starvation counter, and issues them on the bus.
- Tracks in-flight transactions in an ordered tag FIFO so each `data_ok` and its read data return to the requester that issued the transaction.
- Sits between the CPU pipeline and the cache/AXI bridge.

## Interface
- `MAX_OUTSTANDING`, 4: depth of the in-flight tag FIFO; must be a power of two, ≥2.
- `STARVE_LIMIT`, 3: consecutive data grants allowed while inst is waiting before inst is forced.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `inst_req` in 1; `inst_addr` in 32: fetch request (read-only, word size implied).
- `inst_addr_ok` out 1; `inst_data_ok` out 1; `inst_rdata` out 32.
- `data_req` in 1; `data_wr` in 1; `data_size` in 2; `data_addr` in 32; `data_wdata` in 32.
- `data_addr_ok` out 1; `data_data_ok` out 1; `data_rdata` out 32.
- `bus_req` out 1; `bus_wr` out 1; `bus_size` out 2; `bus_addr` out 32; `bus_wdata` out 32.
- `bus_addr_ok` in 1; `bus_data_ok` in 1; `bus_rdata` in 32.
- `proto_err` out 1: sticky; set by `bus_data_ok` while the FIFO is empty.

## Operation
- **Requester contract:** a requester holds `req` and all request fields stable from assertion until its `addr_ok`.
- **Bus contract:** the bus returns `data_ok` strictly in acceptance order.
- **Grant selection when unlocked, in order:**
  - If `data_req` and not starving, grant data.
  - Else if `inst_req`, grant inst.
  - Else if `data_req`, grant data.
  - Starving means `starve_cnt == STARVE_LIMIT` and `inst_req` is asserted.
- **Lock:** when `bus_req` is asserted and `bus_addr_ok` is low, the arbiter registers `locked = 1` and `lock_owner = granted`. While locked, the grant is `lock_owner` regardless of priority. The lock clears on the `bus_addr_ok` handshake.
- **Issue:** `bus_req = granted_req && count < MAX_OUTSTANDING`.
  - Bus fields mux from the granted port.
  - Inst grant drives `bus_wr = 0`, `bus_size = 2'd2`, `bus_wdata = 0`.
- **Acceptance:** on `bus_req && bus_addr_ok`:
  - Assert the granted port's `addr_ok` in the same cycle (combinational).
  - Push a tag: 0 = inst, 1 = data.
  - The other port's `addr_ok` stays 0.
- **Starvation counter:**
  - Increments on a data acceptance while `inst_req` is high, saturating at `STARVE_LIMIT`.
  - Clears on any inst acceptance.
- **Return:** on `bus_data_ok`, pop the head tag.
  - `inst_data_ok = bus_data_ok && head == 0`; `data_data_ok = bus_data_ok && head == 1`.
  - `bus_rdata` is broadcast unregistered to both rdata outputs.
- **Error case:** `bus_data_ok` with `count == 0` pops nothing, asserts neither `data_ok`, and sets `proto_err`.
- **No cancellation support:** cancelled fetches still complete on the bus and return `inst_data_ok`; discarding them is the fetch stage's job.

## Timing
- **Reset values:**
  - `bus_req`, all `addr_ok`/`data_ok` outputs and `proto_err` are 0.
  - `count`, FIFO pointers, `locked` and `starve_cnt` are 0.
  - Bus field and rdata outputs carry the combinational mux/broadcast of their inputs.
- **Reset mid-operation:** drops all in-flight tags. The bus slave must be reset in the same cycle; stray post-reset `data_ok` sets `proto_err`.
- **Latency:** zero-cycle request pass-through (`req` to `bus_req`, `addr_ok` back). The response path is also zero-cycle.
- **Same-cycle push and pop:** allowed, `count` unchanged.
  - When `count == MAX_OUTSTANDING`, issue is blocked even if a pop occurs in that cycle, because the full check uses registered `count`.
  - A pop in a full cycle frees issue from the next cycle.
- **Pointer width:** `log2(MAX_OUTSTANDING)` bits, wrapping naturally. `count` is `log2(MAX_OUTSTANDING)+1` bits.
- **Lock persistence:** persists across any number of stall cycles. A requester dropping `req` while locked violates the contract; behaviour is unspecified.

## Structure
- Shared package constants: `TAG_INST = 1'b0`, `TAG_DATA = 1'b1`, `SIZE_WORD = 2'd2`.
- One natural sub-module: `tag_fifo`, a 1-bit-wide synchronous FIFO of depth `MAX_OUTSTANDING` with push/pop/count/head. The top level holds the arbiter, lock and starvation logic.

## Test plan
- **Simultaneous requests, idle bus:** `inst_req`, `data_req`, `bus_addr_ok = 1` → data accepted cycle 0, inst accepted cycle 1; later two `bus_data_ok` give `data_data_ok` then `inst_data_ok`.
- **Lock hold:** inst requested alone with `bus_addr_ok = 0` for 3 cycles, `data_req` rises in cycle 1 → `bus_addr` stays `inst_addr` until the accept; data is accepted the next cycle.
- **Starvation:** `data_req` and `inst_req` held high, `bus_addr_ok = 1` → data accepted 3 times, inst accepted 4th cycle, data resumes.
- **Full:** 4 accepts with no `data_ok` → `bus_req = 0` with a request pending.
  - One `bus_data_ok` → issue resumes the next cycle.
  - With `bus_data_ok` and a pending request in the same full cycle → no issue that cycle.
- **Interleaved returns:** tags D, I, I, D with `bus_rdata` values 0x11, 0x22, 0x33, 0x44 → `data_data_ok`/0x11, `inst_data_ok`/0x22, `inst_data_ok`/0x33, `data_data_ok`/0x44.
- **Errors and reset:** `bus_data_ok` with an empty FIFO → `proto_err = 1` and stays 1. Reset with 2 outstanding → `count = 0`, `proto_err = 0`, no `data_ok` outputs.
